// File: rtl/data_memory_pipe.sv
// Byte-addressed synchronous data memory with valid/ready request handshake, byte/half/word
// little-endian access, sign/zero-extended loads, configurable read latency and error codes.
module data_memory_pipe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] read_data,
  output logic [1:0]        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] ByteSpan = 32'(DEPTH * 4);
  localparam logic [1:0]  LoadCnt  = 2'(RD_LATENCY - 1);

  localparam logic [1:0] ErrOk    = 2'b00;
  localparam logic [1:0] ErrAlign = 2'b01;
  localparam logic [1:0] ErrRange = 2'b10;
  localparam logic [1:0] ErrSize  = 2'b11;

  typedef enum logic {StIdle, StWait} state_e;

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [1:0]        pend_err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     idx;
  logic [1:0]        err;
  logic              accept;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] word_rd;
  logic [7:0]        byte_rd;
  logic [15:0]       half_rd;
  logic [DATA_W-1:0] load_val;

  assign idx       = address[AW+1:2];
  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready && !rst;

  // Size is checked before range, range before alignment.
  always_comb begin
    err = ErrOk;
    if (req_size == 2'b11) begin
      err = ErrSize;
    end else if (address >= ByteSpan) begin
      err = ErrRange;
    end else if ((req_size == 2'b01 && address[0]) ||
                 (req_size == 2'b10 && address[1:0] != 2'b00)) begin
      err = ErrAlign;
    end
  end

  // Store data is replicated across lanes so each enabled lane picks its own slice.
  always_comb begin
    be    = 4'b0000;
    wdata = write_data;
    unique case (req_size)
      2'b00: begin
        be[address[1:0]] = 1'b1;
        wdata            = {4{write_data[7:0]}};
      end
      2'b01: begin
        be    = address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && err == ErrOk) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  always_comb begin
    word_rd = mem[idx];
    byte_rd = word_rd[{address[1:0], 3'b000} +: 8];
    half_rd = address[1] ? word_rd[31:16] : word_rd[15:0];
    unique case (req_size)
      2'b00: load_val = req_unsigned ? {{(DATA_W-8){1'b0}}, byte_rd}
                                     : {{(DATA_W-8){byte_rd[7]}}, byte_rd};
      2'b01: load_val = req_unsigned ? {{(DATA_W-16){1'b0}}, half_rd}
                                     : {{(DATA_W-16){half_rd[15]}}, half_rd};
      default: load_val = word_rd;
    endcase
  end

  // Load data is captured at accept; the wait only models the read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      pend_data_q <= '0;
      pend_err_q  <= ErrOk;
      resp_valid  <= 1'b0;
      read_data   <= '0;
      resp_err    <= ErrOk;
    end else begin
      resp_valid <= 1'b0;
      read_data  <= '0;
      resp_err   <= ErrOk;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q    <= StWait;
            pend_err_q <= err;
            if (!req_write && err == ErrOk) begin
              pend_data_q <= load_val;
              cnt_q       <= LoadCnt;
            end else begin
              pend_data_q <= '0;
              cnt_q       <= 2'd0;
            end
          end
        end
        StWait: begin
          if (cnt_q == 2'd0) begin
            resp_valid <= 1'b1;
            read_data  <= pend_data_q;
            resp_err   <= pend_err_q;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Scoreboard bench for data_memory_pipe (DEPTH=256, RD_LATENCY=3): the driver queues expected
// responses with their due cycle; a monitor pops and compares on every resp_valid pulse.
module tb_data_memory_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic [1:0]  resp_err;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  data_memory_pipe #(
    .DATA_W    (32),
    .DEPTH     (256),
    .RD_LATENCY(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .address     (address),
    .write_data  (write_data),
    .resp_valid  (resp_valid),
    .read_data   (read_data),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (resp_valid !== 1'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got valid=%b data=%h err=%b at cycle %0d, required none",
                 resp_valid, read_data, resp_err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (read_data !== e.data || resp_err !== e.err || cyc != e.due) begin
          errors++;
          $display("FAIL resp: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d",
                   read_data, resp_err, cyc, e.data, e.err, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic [1:0] exp_e, input bit want);
    int   waited = 0;
    int   lat;
    exp_t e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    address      = addr;
    write_data   = wd;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=%b, required 1 within 50 cycles", req_ready);
    end else if (want) begin
      lat    = (!wr && exp_e == 2'b00) ? 3 : 1;
      e.data = exp_d;
      e.err  = exp_e;
      e.due  = cyc + 1 + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_data"}, read_data, 32'd0);
    chk({tag, "_err"}, {30'd0, resp_err}, 32'd0);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    address      = '0;
    write_data   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    // Word store/load with 3-cycle read latency.
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 1);
    drain();
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 1);
    drain();
    issue(1, 2'b10, 0, 32'h0, 32'h11223344, 32'h0, 2'b00, 1);
    drain();

    // Byte store touches only its lane; extension on byte/half loads.
    issue(1, 2'b00, 0, 32'h11, 32'hAAAAAA80, 32'h0, 2'b00, 1);
    drain();
    issue(0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFF80, 2'b00, 1);
    drain();
    issue(0, 2'b00, 1, 32'h11, 32'h0, 32'h00000080, 2'b00, 1);
    drain();
    issue(0, 2'b10, 1, 32'h10, 32'h0, 32'hDEAD80EF, 2'b00, 1);
    drain();
    issue(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 2'b00, 1);
    drain();
    issue(0, 2'b01, 1, 32'h12, 32'h0, 32'h0000DEAD, 2'b00, 1);
    drain();
    issue(0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFF80EF, 2'b00, 1);
    drain();
    issue(1, 2'b01, 0, 32'h12, 32'h55557FFF, 32'h0, 2'b00, 1);
    drain();
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h7FFF80EF, 2'b00, 1);
    drain();

    // Errors and the top-of-range boundary.
    issue(0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 2'b01, 1);
    drain();
    issue(1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0, 2'b10, 1);
    drain();
    issue(0, 2'b10, 0, 32'h0, 32'h0, 32'h11223344, 2'b00, 1);
    drain();
    issue(1, 2'b10, 0, 32'h11, 32'h99999999, 32'h0, 2'b01, 1);
    drain();
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h7FFF80EF, 2'b00, 1);
    drain();
    issue(0, 2'b11, 0, 32'h400, 32'h0, 32'h0, 2'b11, 1);
    drain();
    issue(1, 2'b00, 0, 32'h3FF, 32'h000000A5, 32'h0, 2'b00, 1);
    drain();
    issue(0, 2'b00, 1, 32'h3FF, 32'h0, 32'h000000A5, 2'b00, 1);
    drain();
    issue(0, 2'b00, 0, 32'h400, 32'h0, 32'h0, 2'b10, 1);
    drain();

    // req_valid held high: ready drops after accept and returns with the response pulse.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'b10;
    address    = 32'h20;
    write_data = 32'h12345678;
    chk("hold_ready_idle", {31'd0, req_ready}, 32'd1);
    begin
      exp_t e;
      e.data = 32'h0;
      e.err  = 2'b00;
      e.due  = cyc + 2;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    chk("hold_ready_drop", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_ready_with_pulse", {31'd0, resp_valid}, 32'd1);
    chk("hold_wait_cycles", n, 32'd1);
    req_write = 1'b0;
    begin
      exp_t e;
      e.data = 32'h12345678;
      e.err  = 2'b00;
      e.due  = cyc + 4;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
    issue(0, 2'b11, 1, 32'h20, 32'h0, 32'h0, 2'b11, 1);
    drain();

    // Reset while a load is pending drops its response.
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 2'b00, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk_reset_state("mid_reset");

    // A store committed just before reset survives it.
    issue(1, 2'b00, 0, 32'h30, 32'h0000005A, 32'h0, 2'b00, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(0, 2'b00, 1, 32'h30, 32'h0, 32'h0000005A, 2'b00, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
